// File: rtl/cry_lut_arb.sv
// CRY colour LUT arbiter: two requesters share the R/G/B lookup ROMs round-robin,
// and the ROM outputs are scaled by pixel intensity into a valid/ready RGB stream.
module cry_lut_arb #(
    parameter int TAGW = 4
) (
    input  logic            sys_clk,
    input  logic            resetl,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [15:0]     req0_cry,
    input  logic [15:0]     req1_cry,
    input  logic [TAGW-1:0] req0_tag,
    input  logic [TAGW-1:0] req1_tag,
    output logic [7:0]      rom_a,
    input  logic [7:0]      rom_r,
    input  logic [7:0]      rom_g,
    input  logic [7:0]      rom_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_r,
    output logic [7:0]      out_g,
    output logic [7:0]      out_b,
    output logic            out_src,
    output logic [TAGW-1:0] out_tag,
    output logic            busy
);

    logic            r_last;
    logic            r_s1_valid;
    logic [7:0]      r_s1_addr;
    logic [7:0]      r_s1_y;
    logic            r_s1_src;
    logic [TAGW-1:0] r_s1_tag;
    logic            r_s2_valid;
    logic [7:0]      r_out_r;
    logic [7:0]      r_out_g;
    logic [7:0]      r_out_b;
    logic            r_out_src;
    logic [TAGW-1:0] r_out_tag;

    logic            w_adv;
    logic            w_gnt_any;
    logic            w_gnt_src;
    logic            w_load;
    logic [15:0]     w_sel_cry;
    logic [TAGW-1:0] w_sel_tag;

    // Y = 0xFF must pass the table value unchanged, hence the +1 on the 9-bit factor.
    function automatic logic [7:0] scale(input logic [7:0] d, input logic [7:0] y);
        logic [16:0] p;
        p = {9'd0, d} * {8'd0, ({1'b0, y} + 9'd1)};
        return p[15:8];
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_gnt_any = |req_valid;
        w_gnt_src = 1'b0;
        if (&req_valid)
            w_gnt_src = ~r_last;
        else
            w_gnt_src = req_valid[1];
        w_adv     = ~r_s2_valid | out_ready;
        w_load    = w_adv & w_gnt_any;
        w_sel_cry = w_gnt_src ? req1_cry : req0_cry;
        w_sel_tag = w_gnt_src ? req1_tag : req0_tag;
        req_ready = 2'b00;
        if (resetl && w_load)
            req_ready = w_gnt_src ? 2'b10 : 2'b01;
        // Without a new grant the S1 address is replayed so ROM data stays aligned with S1.
        rom_a = 8'h00;
        if (resetl)
            rom_a = w_load ? w_sel_cry[15:8] : r_s1_addr;
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!resetl) begin
            r_last     <= 1'b1;
            r_s1_valid <= 1'b0;
            r_s1_addr  <= 8'h00;
            r_s2_valid <= 1'b0;
            r_out_r    <= 8'h00;
            r_out_g    <= 8'h00;
            r_out_b    <= 8'h00;
            r_out_src  <= 1'b0;
            r_out_tag  <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_gnt_any;
            r_s2_valid <= r_s1_valid;
            if (w_gnt_any) begin
                r_last    <= w_gnt_src;
                r_s1_addr <= w_sel_cry[15:8];
            end
            if (r_s1_valid) begin
                r_out_r   <= scale(rom_r, r_s1_y);
                r_out_g   <= scale(rom_g, r_s1_y);
                r_out_b   <= scale(rom_b, r_s1_y);
                r_out_src <= r_s1_src;
                r_out_tag <= r_s1_tag;
            end
        end
    end

    // NOTE: S1 payload has no reset; it is only ever consumed when r_s1_valid is set.
    always_ff @(posedge sys_clk) begin
        if (w_load) begin
            r_s1_y   <= w_sel_cry[7:0];
            r_s1_src <= w_gnt_src;
            r_s1_tag <= w_sel_tag;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_r     = r_out_r;
    assign out_g     = r_out_g;
    assign out_b     = r_out_b;
    assign out_src   = r_out_src;
    assign out_tag   = r_out_tag;
    assign busy      = r_s1_valid | r_s2_valid;

endmodule

// File: tb/tb_cry_lut_arb.sv
// Self-checking bench for cry_lut_arb: registered-read ROM model plus an in-order
// scoreboard of expected pixels computed directly from the colour-scaling rule.
module tb_cry_lut_arb;

    localparam int TAGW = 4;
    localparam int PW   = 25 + TAGW;

    logic            sys_clk;
    logic            resetl;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [15:0]     req0_cry, req1_cry;
    logic [TAGW-1:0] req0_tag, req1_tag;
    logic [7:0]      rom_a, rom_r, rom_g, rom_b;
    logic            out_valid, out_ready;
    logic [7:0]      out_r, out_g, out_b;
    logic            out_src;
    logic [TAGW-1:0] out_tag;
    logic            busy;

    cry_lut_arb #(.TAGW(TAGW)) dut (
        .sys_clk(sys_clk), .resetl(resetl),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_cry(req0_cry), .req1_cry(req1_cry),
        .req0_tag(req0_tag), .req1_tag(req1_tag),
        .rom_a(rom_a), .rom_r(rom_r), .rom_g(rom_g), .rom_b(rom_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .out_src(out_src), .out_tag(out_tag), .busy(busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [7:0] tbl_r(input logic [7:0] a);
        if (a == 8'h4A) return 8'h82;
        return 8'(a * 8'd37 + 8'd11);
    endfunction
    function automatic logic [7:0] tbl_g(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction
    function automatic logic [7:0] tbl_b(input logic [7:0] a);
        return {a[3:0], a[7:4]} + 8'd3;
    endfunction

    always @(posedge sys_clk) begin
        rom_r <= tbl_r(rom_a);
        rom_g <= tbl_g(rom_a);
        rom_b <= tbl_b(rom_a);
    end

    typedef struct {
        logic [7:0]      r, g, b;
        logic            src;
        logic [TAGW-1:0] tag;
        logic [7:0]      addr;
    } pix_t;

    pix_t exp_q[$];
    logic m_last;
    int   n_checks, n_errors;

    logic [1:0]    s_rdy, m_rdy;
    logic          s_ov, s_busy, s_xfer, m_have;
    logic [7:0]    s_rom_a;
    logic [PW-1:0] s_obs;
    pix_t          m_pix;

    function automatic pix_t make_pix(input logic [15:0] cry, input logic [TAGW-1:0] tag, input logic src);
        pix_t p;
        int   f;
        f      = int'(cry[7:0]) + 1;
        p.r    = 8'((int'(tbl_r(cry[15:8])) * f) / 256);
        p.g    = 8'((int'(tbl_g(cry[15:8])) * f) / 256);
        p.b    = 8'((int'(tbl_b(cry[15:8])) * f) / 256);
        p.src  = src;
        p.tag  = tag;
        p.addr = cry[15:8];
        return p;
    endfunction

    function automatic logic [PW-1:0] pix_vec(input pix_t p);
        return {p.r, p.g, p.b, p.src, p.tag};
    endfunction

    // Round-robin rule: on contention the requester not served last wins.
    function automatic logic [1:0] model_grant(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    // Drive one cycle, sample just after inputs settle, advance the reference model, then cross the edge.
    task automatic step(input logic rst, input logic [1:0] v, input logic ordy);
        resetl    = rst;
        req_valid = v;
        out_ready = ordy;
        #1;
        s_rdy   = req_ready;
        s_ov    = out_valid;
        s_busy  = busy;
        s_rom_a = rom_a;
        s_obs   = {out_r, out_g, out_b, out_src, out_tag};
        m_rdy   = (rst && (!out_valid || ordy)) ? model_grant(v, m_last) : 2'b00;
        s_xfer  = rst && out_valid && ordy;
        m_have  = 1'b0;
        if (s_xfer && exp_q.size() > 0) begin
            m_pix  = exp_q.pop_front();
            m_have = 1'b1;
        end
        if (rst && (s_rdy & v) != 2'b00) begin
            if (s_rdy[1]) exp_q.push_back(make_pix(req1_cry, req1_tag, 1'b1));
            else          exp_q.push_back(make_pix(req0_cry, req0_tag, 1'b0));
            m_last = s_rdy[1];
        end
        if (!rst) begin
            exp_q.delete();
            m_last = 1'b1;
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_drain(input string name);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 2'b00, 1'b1);
            if (s_xfer) begin
                n_checks++;
                if (!m_have || s_obs !== pix_vec(m_pix)) begin
                    n_errors++;
                    $display("FAIL %s_pixel: got %h want %h (expected present=%0b)", name, s_obs, pix_vec(m_pix), m_have);
                end
            end
            if (exp_q.size() == 0 && !s_busy && !s_ov) break;
        end
        n_checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_empty: pending=%0d busy=%b want pending=0 busy=0", name, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        req0_cry = 16'h1111; req1_cry = 16'h2222; req0_tag = 1; req1_tag = 2;
        step(1'b0, 2'b11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b11, 1'b1);
            n_checks++;
            if ({s_rdy, s_ov, s_busy, s_rom_a, s_obs} !== '0) begin
                n_errors++;
                $display("FAIL reset_state: ready=%b valid=%b busy=%b rom_a=%h out=%h want all zero",
                         s_rdy, s_ov, s_busy, s_rom_a, s_obs);
            end
        end
        step(1'b1, 2'b11, 1'b1);
        n_checks++;
        if (s_rdy !== 2'b01) begin
            n_errors++;
            $display("FAIL reset_first_grant: got %b want 01", s_rdy);
        end
        test_drain("reset");
    endtask

    task automatic test_single_pixel();
        logic [7:0] ys[3]  = '{8'hFF, 8'h80, 8'h00};
        logic [7:0] exr[3] = '{8'h82, 8'h41, 8'h00};
        for (int k = 0; k < 3; k++) begin
            req0_cry = {8'h4A, ys[k]};
            req0_tag = 4'd5;
            step(1'b1, 2'b01, 1'b1);
            n_checks++;
            if (s_rdy !== 2'b01) begin
                n_errors++;
                $display("FAIL single_accept: got %b want 01", s_rdy);
            end
            step(1'b1, 2'b00, 1'b1);
            n_checks++;
            if (s_ov !== 1'b0) begin
                n_errors++;
                $display("FAIL single_early_valid: got %b want 0", s_ov);
            end
            step(1'b1, 2'b00, 1'b1);
            n_checks++;
            if (s_ov !== 1'b1 || s_obs[PW-1 -: 8] !== exr[k] || s_obs[TAGW:0] !== {1'b0, 4'd5}) begin
                n_errors++;
                $display("FAIL single_y%h: valid=%b r=%h src/tag=%h want valid=1 r=%h src/tag=05",
                         ys[k], s_ov, s_obs[PW-1 -: 8], s_obs[TAGW:0], exr[k]);
            end
            n_checks++;
            if (!m_have || s_obs !== pix_vec(m_pix)) begin
                n_errors++;
                $display("FAIL single_gb_y%h: got %h want %h", ys[k], s_obs, pix_vec(m_pix));
            end
            test_drain("single");
        end
    endtask

    task automatic test_contention();
        logic [1:0] prev;
        prev = 2'b00;
        for (int i = 0; i < 8; i++) begin
            req0_cry = 16'($urandom); req1_cry = 16'($urandom);
            req0_tag = 4'($urandom);  req1_tag = 4'($urandom);
            step(1'b1, 2'b11, 1'b1);
            n_checks++;
            if (s_rdy !== m_rdy || (prev != 2'b00 && s_rdy !== {prev[0], prev[1]})) begin
                n_errors++;
                $display("FAIL contention_grant%0d: got %b want %b (previous %b)", i, s_rdy, m_rdy, prev);
            end
            prev = s_rdy;
            if (i >= 2) begin
                n_checks++;
                if (!s_xfer || !m_have || s_obs !== pix_vec(m_pix)) begin
                    n_errors++;
                    $display("FAIL contention_out%0d: valid=%b got %h want %h", i, s_ov, s_obs, pix_vec(m_pix));
                end
            end
        end
        test_drain("contention");
    endtask

    task automatic test_back_pressure();
        req0_cry = 16'h4AC0; req0_tag = 4'd3;
        req1_cry = 16'h9D37; req1_tag = 4'd9;
        step(1'b1, 2'b11, 1'b1);
        step(1'b1, 2'b11, 1'b1);
        for (int i = 0; i < 4; i++) begin
            req0_cry = {8'h10 + 8'(i), 8'h77};
            req1_cry = {8'hE0 + 8'(i), 8'h55};
            step(1'b1, 2'b11, 1'b0);
            n_checks++;
            if (exp_q.size() != 2) begin
                n_errors++;
                $display("FAIL bp_occupancy: pending=%0d want 2", exp_q.size());
            end else if (s_rdy !== 2'b00 || s_ov !== 1'b1 || s_rom_a !== exp_q[1].addr ||
                         s_obs !== pix_vec(exp_q[0])) begin
                n_errors++;
                $display("FAIL bp_hold%0d: ready=%b valid=%b rom_a=%h out=%h want ready=00 valid=1 rom_a=%h out=%h",
                         i, s_rdy, s_ov, s_rom_a, s_obs, exp_q[1].addr, pix_vec(exp_q[0]));
            end
        end
        test_drain("bp");
    endtask

    task automatic test_reset_mid_stream();
        for (int i = 0; i < 3; i++) begin
            req0_cry = 16'($urandom); req1_cry = 16'($urandom);
            step(1'b1, 2'b11, 1'b1);
        end
        step(1'b0, 2'b11, 1'b1);
        n_checks++;
        if (s_rdy !== 2'b00 || s_rom_a !== 8'h00) begin
            n_errors++;
            $display("FAIL midreset_comb: ready=%b rom_a=%h want 00/00", s_rdy, s_rom_a);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'b00, 1'b1);
            n_checks++;
            if (s_ov !== 1'b0 || s_busy !== 1'b0) begin
                n_errors++;
                $display("FAIL midreset_flush%0d: valid=%b busy=%b want 0/0", i, s_ov, s_busy);
            end
        end
        step(1'b1, 2'b11, 1'b1);
        n_checks++;
        if (s_rdy !== 2'b01) begin
            n_errors++;
            $display("FAIL midreset_grant: got %b want 01", s_rdy);
        end
        test_drain("midreset");
    endtask

    task automatic test_random();
        logic [1:0] v;
        logic       ordy;
        for (int i = 0; i < 10000; i++) begin
            v        = 2'($urandom);
            ordy     = ($urandom_range(3) != 0);
            req0_cry = 16'($urandom);
            req1_cry = 16'($urandom);
            if ($urandom_range(7) == 0) req0_cry[7:0] = 8'hFF;
            if ($urandom_range(7) == 0) req1_cry[7:0] = 8'h00;
            req0_tag = 4'($urandom);
            req1_tag = 4'($urandom);
            step(1'b1, v, ordy);
            n_checks++;
            if (s_rdy !== m_rdy) begin
                n_errors++;
                $display("FAIL random_ready@%0d: got %b want %b (valid=%b)", i, s_rdy, m_rdy, v);
            end
            if (s_xfer) begin
                n_checks++;
                if (!m_have || s_obs !== pix_vec(m_pix)) begin
                    n_errors++;
                    $display("FAIL random_pixel@%0d: got %h want %h (expected present=%0b)",
                             i, s_obs, pix_vec(m_pix), m_have);
                end
            end
        end
        test_drain("random");
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        m_last    = 1'b1;
        resetl    = 1'b0;
        req_valid = 2'b00;
        out_ready = 1'b1;
        req0_cry  = '0; req1_cry = '0;
        req0_tag  = '0; req1_tag = '0;
        test_reset();
        test_single_pixel();
        test_contention();
        test_back_pressure();
        test_reset_mid_stream();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cry_lut_arb.md
# cry_lut_arb

Two-port arbiter and sequencer for the shared CRY colour lookup ROMs: the red, green and blue 256x8 tables with a registered read on `sys_clk`. It accepts 16-bit CRY pixels from two requesters, for example the object-processor line-buffer path and the blitter colour path, and grants one per cycle round-robin. It drives the common ROM address, replays that address under back-pressure, and scales the three table outputs by pixel intensity into 8-bit RGB with a valid/ready output.

## Interface
- `TAGW`, default 4: width of the per-request tag carried through to the output.
- `sys_clk`, in, 1: the single clock; the ROMs share it.
- `resetl`, in, 1: synchronous, active-low reset.
- `req_valid[1:0]`, in, 2: request valid, one bit per requester.
- `req_ready[1:0]`, out, 2: request accepted this cycle when `valid` and `ready` are both high.
- `req0_cry`, `req1_cry`, in, 16: CRY pixel. Bits [15:12] cyan, [11:8] red, [7:0] intensity Y.
- `req0_tag`, `req1_tag`, in, TAGW: opaque tag.
- `rom_a`, out, 8: shared ROM address `{cyan, red}`.
- `rom_r`, `rom_g`, `rom_b`, in, 8: ROM data; reflects the `rom_a` sampled at the previous edge.
- `out_valid`, out, 1: output pixel valid.
- `out_ready`, in, 1: downstream accepts.
- `out_r`, `out_g`, `out_b`, out, 8: scaled colour.
- `out_src`, out, 1: index of the requester that issued the pixel.
- `out_tag`, out, TAGW: tag of that pixel.
- `busy`, out, 1: pipeline holds any valid entry.

## Operation
- Two stages:
  - S1 holds the metadata (Y, tag, source, address, valid) aligned with the ROM's internal register.
  - S2 is the output register.
- Advance condition: `adv = !out_valid | out_ready`.
- Arbitration is combinational over `req_valid` using pointer `last` (last accepted source):
  - Both valid: grant `!last`.
  - One valid: grant that one.
  - `req_ready[i] = adv & grant[i] & resetl`.
- `last` updates only on an accepted transfer. After reset `last` = 1, so requester 0 wins the first contention.
- `rom_a`:
  - adv with a grant: `{cry[15:8]}` of the granted request.
  - otherwise: the S1 address (replay), so ROM data stays aligned with S1.
  - 0 while `resetl` = 0.
- On an adv edge:
  - S1 is loaded with the granted request; S1 valid = grant present.
  - S2 is loaded from S1 and the ROM data; `out_valid` = S1 valid.
- When S1 is invalid at adv, S2 loads `out_valid` = 0 and its data fields are don't-care (the implementation holds them).
- Scaling: `out_x = (rom_x * ({1'b0,Y} + 1))[15:8]`. This is an 8x9 unsigned multiply, 17-bit product, no rounding.
  - Y = 0xFF passes `rom_x` unchanged.
  - Y = 0x00 gives 0.
- `busy = S1.valid | out_valid`.
- Reset (`resetl` low at an edge), mid-operation included:
  - S1 and S2 valid are cleared; in-flight pixels are dropped.
  - `out_r/g/b`, `out_tag`, `out_src` = 0; `last` = 1.
  - `req_ready` is 0 while `resetl` is low.

## Timing
- Latency: a request accepted at edge t sees the ROM sample its address at t. `out_valid` rises after edge t+1, provided `adv` was high at t+1.
- Throughput: one pixel per cycle while `out_ready` stays high.
- `out_ready` low with `out_valid` high:
  - `adv` = 0 and `req_ready` = 0.
  - S1, S2 and `last` hold.
  - `rom_a` replays the S1 address each edge.
  - Outputs stay stable until the accepting edge.
- Combinational paths:
  - `out_ready` to `req_ready`.
  - `req_valid` to `rom_a`.
- No combinational path from `req_valid` to `out_valid`.

## Test plan
- Bench ROM model with registered read; red table with entry 0x4A = 0x82.
- Reset: hold `resetl` low 3 cycles with both requests valid -> `req_ready` = 00, `out_valid` = 0, `rom_a` = 0x00, outputs 0. First grant after release goes to requester 0.
- Single pixel: req0 CRY 0x4AFF, tag 5, `out_ready` = 1 -> `out_valid` high two edges after acceptance with `out_r` = 0x82, `out_src` = 0, `out_tag` = 5. Repeat with CRY 0x4A80 -> `out_r` = 0x41; with CRY 0x4A00 -> `out_r` = 0x00.
- Contention: both requesters valid continuously for 8 cycles -> grants alternate 0,1,0,1…; `out_src` sequence matches; one output per cycle.
- Back-pressure: drop `out_ready` for 4 cycles with S1 and S2 full -> `rom_a` holds the S1 address, `req_ready` = 00, outputs stable. On release the S1 pixel emerges with correct colour (no data from a newer address), then normal flow resumes.
- Reset mid-stream: assert `resetl` low while S1 and S2 are valid -> next cycle `out_valid` = 0 and `busy` = 0. No stale pixel appears after release.
- Randomised: random `req_valid`, `out_ready` and CRY values over 10k cycles -> scoreboard output colour, tag, source and per-source order. No request starved beyond one grant while the other requester is also valid.
